// File: rtl/filter_pkg.sv
// Shared constants for the 3x3 kernel filter: mode encodings, window slot
// numbering and the identity coefficient for a given output shift.
package filter_pkg;
  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_CONV   = 2'b01;
  localparam logic [1:0] MODE_ABS    = 2'b10;

  localparam int N_TAPS         = 9;
  localparam int SLOT_CENTRE    = 8;
  localparam int SLOT_LEFT      = 7;
  localparam int SLOT_RIGHT     = 6;
  localparam int SLOT_UP        = 5;
  localparam int SLOT_DOWN      = 4;
  localparam int SLOT_UPLEFT    = 3;
  localparam int SLOT_UPRIGHT   = 2;
  localparam int SLOT_DOWNLEFT  = 1;
  localparam int SLOT_DOWNRIGHT = 0;

  function automatic int identity_coef(input int shift);
    return 1 << shift;
  endfunction
endpackage

// File: rtl/kernel3x3_filter_if.sv
// Pixel stream and coefficient-write bus between the window generator (master)
// and the filter (slave).
interface kernel3x3_filter_if #(
  parameter int CH_W   = 4,
  parameter int CH     = 3,
  parameter int COEF_W = 8
);
  localparam int PX = CH * CH_W;

  // Both streams use strict valid/ready: a beat moves on the rising edge where
  // valid && ready; the source holds data stable and keeps valid up until then.
  logic [9*PX-1:0]   win_data;
  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [PX-1:0]     pix_out;
  logic [PX-1:0]     orig_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output win_data, mode, in_valid, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, pix_out, orig_out, out_valid
  );

  modport slave (
    input  win_data, mode, in_valid, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, pix_out, orig_out, out_valid
  );
endinterface

// File: rtl/filter_chan.sv
// One colour channel: 9-tap multiply (S1), adder tree (S2), shift/clamp/mode (S3).
// All stages advance together and hold while stall is high.
module filter_chan
  import filter_pkg::*;
#(
  parameter int CH_W   = 4,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_TAPS-1:0][CH_W-1:0]    taps,
  input  logic [N_TAPS-1:0][COEF_W-1:0]  coefs,
  input  logic [1:0]                     mode,
  input  logic                           stall,
  output logic [CH_W-1:0]                pix
);
  localparam int PROD_W = CH_W + COEF_W + 1;
  localparam int SUM_W  = PROD_W + 4;
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << CH_W) - 1);

  logic [N_TAPS-1:0][PROD_W-1:0] prod_d, prod_q;
  logic [1:0]                    mode1_d, mode1_q, mode2_d, mode2_q;
  logic [CH_W-1:0]               ctr1_d, ctr1_q, ctr2_d, ctr2_q;
  logic signed [SUM_W-1:0]       sum_d, sum_q;
  logic signed [SUM_W-1:0]       res, mag;
  logic [CH_W-1:0]               pix_d, pix_q;

  // Pixel is zero-extended, coefficient sign-extended, so the product is exact.
  function automatic logic [PROD_W-1:0] mul(input logic [CH_W-1:0] p,
                                            input logic [COEF_W-1:0] c);
    logic signed [PROD_W-1:0] pe, ce;
    pe = {{(PROD_W-CH_W){1'b0}}, p};
    ce = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
    return pe * ce;
  endfunction

  function automatic logic [CH_W-1:0] clamp(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1]) return '0;
    if (v > PIX_MAX) return '1;
    return v[CH_W-1:0];
  endfunction

  always_comb begin
    prod_d  = prod_q;
    mode1_d = mode1_q;
    ctr1_d  = ctr1_q;
    if (!stall) begin
      for (int k = 0; k < N_TAPS; k++) prod_d[k] = mul(taps[k], coefs[k]);
      mode1_d = mode;
      ctr1_d  = taps[SLOT_CENTRE];
    end
  end

  always_comb begin
    sum_d   = sum_q;
    mode2_d = mode2_q;
    ctr2_d  = ctr2_q;
    if (!stall) begin
      sum_d = '0;
      for (int k = 0; k < N_TAPS; k++) sum_d = sum_d + SUM_W'($signed(prod_q[k]));
      mode2_d = mode1_q;
      ctr2_d  = ctr1_q;
    end
  end

  always_comb begin
    res   = sum_q >>> SHIFT;
    mag   = res[SUM_W-1] ? -res : res;
    pix_d = pix_q;
    if (!stall) begin
      case (mode2_q)
        MODE_CONV: pix_d = clamp(res);
        MODE_ABS:  pix_d = clamp(mag);
        default:   pix_d = ctr2_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q  <= '0;
      mode1_q <= '0;
      ctr1_q  <= '0;
      sum_q   <= '0;
      mode2_q <= '0;
      ctr2_q  <= '0;
      pix_q   <= '0;
    end else begin
      prod_q  <= prod_d;
      mode1_q <= mode1_d;
      ctr1_q  <= ctr1_d;
      sum_q   <= sum_d;
      mode2_q <= mode2_d;
      ctr2_q  <= ctr2_d;
      pix_q   <= pix_d;
    end
  end

  assign pix = pix_q;
endmodule

// File: rtl/kernel3x3_filter.sv
// 3x3 convolution filter top: coefficient bank, valid/stall control, centre-pixel
// delay line, and one filter_chan per colour channel.
module kernel3x3_filter
  import filter_pkg::*;
#(
  parameter int CH_W   = 4,
  parameter int CH     = 3,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 3
) (
  input logic              clk,
  input logic              reset_n,
  kernel3x3_filter_if.slave bus
);
  localparam int PX = CH * CH_W;
  localparam logic [COEF_W-1:0] IDENT = COEF_W'(identity_coef(SHIFT));

  logic [N_TAPS-1:0][COEF_W-1:0] coef_d, coef_q;
  logic                          v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic [PX-1:0]                 orig1_d, orig1_q, orig2_d, orig2_q, orig3_d, orig3_q;
  logic [CH-1:0][CH_W-1:0]       pix_chan;
  logic                          stall;

  assign stall         = v3_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = v3_q;
  assign bus.pix_out   = pix_chan;
  assign bus.orig_out  = orig3_q;

  // The bank is sampled by S1 on the accepting edge, so a write on that same
  // edge only reaches later pixels.
  always_comb begin
    coef_d = coef_q;
    if (bus.coef_we && (bus.coef_addr < 4'(N_TAPS))) coef_d[bus.coef_addr] = bus.coef_data;
  end

  always_comb begin
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    orig1_d = orig1_q;
    orig2_d = orig2_q;
    orig3_d = orig3_q;
    if (!stall) begin
      v1_d    = bus.in_valid;
      v2_d    = v1_q;
      v3_d    = v2_q;
      orig1_d = bus.win_data[SLOT_CENTRE*PX +: PX];
      orig2_d = orig1_q;
      orig3_d = orig2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_TAPS; k++) coef_q[k] <= (k == SLOT_CENTRE) ? IDENT : '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      orig1_q <= '0;
      orig2_q <= '0;
      orig3_q <= '0;
    end else begin
      coef_q  <= coef_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      orig1_q <= orig1_d;
      orig2_q <= orig2_d;
      orig3_q <= orig3_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    logic [N_TAPS-1:0][CH_W-1:0] taps;
    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
      assign taps[k] = bus.win_data[k*PX + c*CH_W +: CH_W];
    end

    filter_chan #(
      .CH_W  (CH_W),
      .COEF_W(COEF_W),
      .SHIFT (SHIFT)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .taps   (taps),
      .coefs  (coef_q),
      .mode   (bus.mode),
      .stall  (stall),
      .pix    (pix_chan[c])
    );
  end
endmodule

// File: tb/tb_kernel3x3_filter.sv
// Directed bench for kernel3x3_filter: driver tasks push expected {pix, orig}
// into a queue on accept, a monitor pops and compares on every output transfer.
module tb_kernel3x3_filter;
  localparam int CH_W   = 4;
  localparam int CH     = 3;
  localparam int COEF_W = 8;
  localparam int SHIFT  = 3;
  localparam int PX     = CH * CH_W;
  localparam int WW     = 9 * PX;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [2*PX-1:0] exp_q[$];

  kernel3x3_filter_if #(.CH_W(CH_W), .CH(CH), .COEF_W(COEF_W)) bus ();

  kernel3x3_filter #(
    .CH_W  (CH_W),
    .CH    (CH),
    .COEF_W(COEF_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] mk_win(input logic [PX-1:0] centre, input logic [PX-1:0] nb);
    logic [WW-1:0] w;
    for (int k = 0; k < 8; k++) w[k*PX +: PX] = nb;
    w[8*PX +: PX] = centre;
    return w;
  endfunction

  function automatic logic [WW-1:0] rnd_win(input logic [PX-1:0] centre);
    logic [WW-1:0] w;
    for (int k = 0; k < 8; k++) w[k*PX +: PX] = PX'($urandom_range(0, 4095));
    w[8*PX +: PX] = centre;
    return w;
  endfunction

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic send(input logic [WW-1:0] win, input logic [1:0] m, input logic [PX-1:0] exp_pix);
    int guard;
    guard = 0;
    bus.win_data = win;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    else exp_q.push_back({exp_pix, win[8*PX +: PX]});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wcoef(input logic [3:0] addr, input logic [COEF_W-1:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr;
    bus.coef_data = data;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic load_identity();
    for (int k = 0; k < 8; k++) wcoef(4'(k), 8'h00);
    wcoef(4'd8, 8'h08);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [2*PX-1:0] e;
    logic [2*PX-1:0] held;
    logic            was_stall;
    was_stall = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        was_stall = 1'b0;
        continue;
      end
      if (was_stall) begin
        chk("stall_valid_hold", 32'(bus.out_valid), 32'd1);
        chk("stall_data_hold", 32'({bus.pix_out, bus.orig_out}), 32'(held));
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("in_ready_stalled", 32'(bus.in_ready), 32'd0);
        held      = {bus.pix_out, bus.orig_out};
        was_stall = 1'b1;
      end else begin
        chk("in_ready_free", 32'(bus.in_ready), 32'd1);
        was_stall = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(bus.pix_out), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pix_out", 32'(bus.pix_out), 32'(e[2*PX-1:PX]));
          chk("orig_out", 32'(bus.orig_out), 32'(e[PX-1:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.win_data  = '0;
    bus.mode      = 2'b00;
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pix_out", 32'(bus.pix_out), 32'd0);
    chk("rst_orig_out", 32'(bus.orig_out), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // identity kernel after reset, every mode returns the centre pixel
    send(rnd_win(12'hA5C), 2'b01, 12'hA5C);
    send(rnd_win(12'h3C7), 2'b00, 12'h3C7);
    send(rnd_win(12'h5E1), 2'b11, 12'h5E1);
    send(rnd_win(12'h9F0), 2'b10, 12'h9F0);
    drain();

    // box blur
    for (int k = 0; k < 9; k++) wcoef(4'(k), 8'h01);
    send(mk_win(12'hFFF, 12'hFFF), 2'b01, 12'hFFF);
    send(mk_win(12'h111, 12'h111), 2'b01, 12'h111);
    send(mk_win(12'h888, 12'h888), 2'b01, 12'h999);
    send(mk_win(12'h888, 12'h888), 2'b00, 12'h888);
    drain();

    // laplacian
    for (int k = 0; k < 8; k++) wcoef(4'(k), 8'hFF);
    wcoef(4'd8, 8'h08);
    send(mk_win(12'h888, 12'h888), 2'b01, 12'h000);
    send(mk_win(12'h000, 12'h444), 2'b01, 12'h000);
    send(mk_win(12'h000, 12'h444), 2'b10, 12'h444);
    send(mk_win(12'hF00, 12'h000), 2'b01, 12'hF00);
    send(mk_win(12'h123, 12'h000), 2'b10, 12'h123);
    send(mk_win(12'h000, 12'h444), 2'b00, 12'h000);
    drain();

    // backpressure mid-stream
    load_identity();
    fork
      begin
        send(rnd_win(12'h101), 2'b01, 12'h101);
        send(rnd_win(12'h202), 2'b10, 12'h202);
        send(rnd_win(12'h303), 2'b00, 12'h303);
        send(rnd_win(12'h404), 2'b01, 12'h404);
        send(rnd_win(12'h505), 2'b11, 12'h505);
        send(rnd_win(12'h606), 2'b01, 12'h606);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // coef write on the accepting edge affects only the following pixel
    bus.win_data  = rnd_win(12'h6B2);
    bus.mode      = 2'b01;
    bus.in_valid  = 1'b1;
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'd8;
    bus.coef_data = 8'h00;
    @(negedge clk);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back({12'h6B2, 12'h6B2});
    @(posedge clk);
    #1;
    bus.coef_we  = 1'b0;
    bus.in_valid = 1'b0;
    send(rnd_win(12'h6B2), 2'b01, 12'h000);
    drain();

    // out-of-range addresses leave the bank untouched
    wcoef(4'd8, 8'h08);
    wcoef(4'd12, 8'h40);
    wcoef(4'd9, 8'h40);
    wcoef(4'd15, 8'h40);
    send(mk_win(12'h111, 12'h111), 2'b01, 12'h111);
    send(mk_win(12'hFFF, 12'h777), 2'b01, 12'hFFF);
    drain();

    // reset with three pixels in flight
    wcoef(4'd8, 8'h10);
    send(mk_win(12'h111, 12'h111), 2'b01, 12'h222);
    send(mk_win(12'h111, 12'h111), 2'b01, 12'h222);
    send(mk_win(12'h111, 12'h111), 2'b01, 12'h222);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_pix_out", 32'(bus.pix_out), 32'd0);
    chk("midrst_orig_out", 32'(bus.orig_out), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(mk_win(12'h111, 12'h111), 2'b01, 12'h111);
    send(mk_win(12'h000, 12'h444), 2'b10, 12'h000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
